logic_reduce_np: RTL and testbench

LOGIC_REDUCE_NP -- requirements
Module: logic_reduce_np

---
 rtl/logic_reduce_np.sv | 115 +++++++++++
 tb/tb_logic_reduce_np.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/logic_reduce_np.sv
// Multi-cycle bitwise reduction (AND/OR/XOR/NOR) over N captured operands.
// It combines one operand per clock and holds the result under valid/ready backpressure.
module logic_reduce_np #(
  parameter int N = 4,
  parameter int D = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [1:0]          i_op,
  input  logic [N-1:0][D-1:0] i_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [D-1:0]        o_result,
  output logic                o_busy
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] FIRST_IDX = IW'(1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state, state_nxt;
  logic [N-1:0][D-1:0] opnd_q;
  logic [1:0]          op_q;
  logic [D-1:0]        acc_q;
  logic [D-1:0]        acc_nxt;
  logic [D-1:0]        res_q;
  logic [IW-1:0]       idx_q;
  logic                last;

  // NOR accumulates as OR; the inversion happens only on the final store.
  function automatic logic [D-1:0] combine(input logic [1:0] op,
                                           input logic [D-1:0] a,
                                           input logic [D-1:0] b);
    logic [D-1:0] r;
    case (op)
      2'b00:   r = a & b;
      2'b10:   r = a ^ b;
      default: r = a | b;
    endcase
    return r;
  endfunction

  function automatic logic [D-1:0] finalize(input logic [1:0] op,
                                            input logic [D-1:0] a);
    return (op == 2'b11) ? ~a : a;
  endfunction

  assign last    = (idx_q == LAST_IDX);
  assign acc_nxt = combine(op_q, acc_q, opnd_q[idx_q]);
  assign o_result = res_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_busy    = 1'b0;
    o_valid   = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nxt = BUSY;
      end
      BUSY: begin
        o_busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      opnd_q <= '0;
      op_q   <= '0;
      acc_q  <= '0;
      idx_q  <= '0;
      res_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            opnd_q <= i_data;
            op_q   <= i_op;
            acc_q  <= i_data[0];
            idx_q  <= FIRST_IDX;
          end
        end
        BUSY: begin
          acc_q <= acc_nxt;
          if (last) begin
            // Park the index at 0 so it never runs past N-1.
            idx_q <= '0;
            res_q <= finalize(op_q, acc_nxt);
          end else begin
            idx_q <= idx_q + FIRST_IDX;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_reduce_np.sv
// Directed bench for logic_reduce_np: a fold-based reference model checked every cycle,
// plus literal expectations for latency, results, backpressure and reset.
module tb_logic_reduce_np;

  localparam int N = 4;
  localparam int D = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                i_valid = 1'b0;
  logic [1:0]          i_op = 2'b00;
  logic [N-1:0][D-1:0] i_data = '0;
  logic                i_ready = 1'b0;
  logic                o_ready, o_valid, o_busy;
  logic [D-1:0]        o_result;

  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;
  bit check_en = 1'b0;

  logic_reduce_np #(.N(N), .D(D)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [D-1:0] ref_reduce(input logic [1:0] op,
                                              input logic [N-1:0][D-1:0] d);
    logic [D-1:0] r;
    r = d[0];
    for (int i = 1; i < N; i++) begin
      if (op == 2'b00)      r = r & d[i];
      else if (op == 2'b10) r = r ^ d[i];
      else                  r = r | d[i];
    end
    if (op == 2'b11) r = ~r;
    return r;
  endfunction

  // Reference model: edges left before the result appears, and whether a result is held.
  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [D-1:0] m_pend = '0;
  logic [D-1:0] m_res  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_pend <= '0;
      m_res  <= '0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_res  <= m_pend;
        m_done <= 1'b1;
      end
    end else if (m_done) begin
      if (i_ready) m_done <= 1'b0;
    end else if (i_valid) begin
      m_left <= N - 1;
      m_pend <= ref_reduce(i_op, i_data);
    end
  end

  always @(posedge clk) if (rst_n && o_valid && i_ready) hs_cnt++;

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_valid", 32'(o_valid), 32'(m_done));
      chk("model_busy", 32'(o_busy), 32'(m_left != 0));
      chk("model_ready", 32'(o_ready), 32'(!m_done && m_left == 0));
      chk("model_result", 32'(o_result), 32'(m_res));
    end
  end

  // Called at posedge+2 with the DUT idle; returns at posedge+2 back in IDLE.
  task automatic run_txn(input string name, input logic [1:0] op,
                         input logic [D-1:0] d0, input logic [D-1:0] d1,
                         input logic [D-1:0] d2, input logic [D-1:0] d3,
                         input logic [D-1:0] exp, input int hold, input bit mid);
    int lat;
    int hs0;
    int w;
    w = 0;
    while (!o_ready && w < 20) begin
      @(posedge clk); #2; w++;
    end
    chk({name, "_ready_wait"}, 32'(o_ready), 32'd1);
    hs0 = hs_cnt;
    i_valid = 1'b1;
    i_op = op;
    i_data[0] = d0; i_data[1] = d1; i_data[2] = d2; i_data[3] = d3;
    @(posedge clk); #2;
    i_valid = 1'b0;
    if (mid) begin
      i_valid = 1'b1;
      i_op = ~op;
      i_data[0] = 16'h1234; i_data[1] = 16'h0F0F; i_data[2] = 16'hAAAA; i_data[3] = 16'h5555;
    end
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(posedge clk); #2; lat++;
      if (mid && lat == 1) begin
        i_valid = 1'b0;
        i_op = 2'b01;
        i_data[0] = 16'hFFFF;
      end
    end
    chk({name, "_latency"}, 32'(lat), 32'd3);
    chk({name, "_result"}, 32'(o_result), 32'(exp));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #2;
      chk({name, "_bp_valid"}, 32'(o_valid), 32'd1);
      chk({name, "_bp_result"}, 32'(o_result), 32'(exp));
    end
    i_ready = 1'b1;
    @(posedge clk); #2;
    i_ready = 1'b0;
    chk({name, "_ready_after"}, 32'(o_ready), 32'd1);
    chk({name, "_valid_after"}, 32'(o_valid), 32'd0);
    chk({name, "_result_kept"}, 32'(o_result), 32'(exp));
    chk({name, "_one_result"}, 32'(hs_cnt - hs0), 32'd1);
  endtask

  initial begin
    int hs0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_ready", 32'(o_ready), 32'd1);
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_result", 32'(o_result), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    check_en = 1'b1;
    chk("model_pin_or", 32'(ref_reduce(2'b01, {16'h1000, 16'h0100, 16'h0010, 16'h0001})), 32'h1111);
    chk("model_pin_nor", 32'(ref_reduce(2'b11, {16'h0000, 16'h0000, 16'h0000, 16'h8000})), 32'h7FFF);

    run_txn("or",   2'b01, 16'h0001, 16'h0010, 16'h0100, 16'h1000, 16'h1111, 0, 1'b0);
    run_txn("and",  2'b00, 16'hFFFF, 16'hF0F0, 16'hFF00, 16'hFFFF, 16'hF000, 2, 1'b0);
    run_txn("xor",  2'b10, 16'h00FF, 16'h0F0F, 16'h3333, 16'h0000, 16'h3CC3, 0, 1'b0);
    run_txn("nor0", 2'b11, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 0, 1'b0);
    run_txn("nor1", 2'b11, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 5, 1'b0);
    run_txn("mid",  2'b00, 16'hFFFF, 16'hF0F0, 16'hFF00, 16'hFFFF, 16'hF000, 1, 1'b1);

    // Abort a transaction with an asynchronous reset between clock edges.
    hs0 = hs_cnt;
    i_valid = 1'b1;
    i_op = 2'b01;
    i_data[0] = 16'h00F0; i_data[1] = 16'h0F00; i_data[2] = 16'h000F; i_data[3] = 16'hF000;
    @(posedge clk); #2;
    i_valid = 1'b0;
    @(posedge clk); #2;
    chk("abort_busy_before", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_ready", 32'(o_ready), 32'd1);
    chk("abort_result", 32'(o_result), 32'd0);
    chk("abort_valid", 32'(o_valid), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #2;
      chk("abort_no_valid", 32'(o_valid), 32'd0);
    end
    chk("abort_no_result", 32'(hs_cnt - hs0), 32'd0);

    run_txn("post_rst", 2'b10, 16'h00FF, 16'h0F0F, 16'h3333, 16'h0000, 16'h3CC3, 1, 1'b0);
    run_txn("or2",      2'b01, 16'h8001, 16'h4002, 16'h2004, 16'h1008, 16'hF00F, 0, 1'b0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
